// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter: shares one rggen common register bus between several
// upstream requesters. Round-robin or fixed-priority selection, one transfer
// in flight downstream, response routed combinationally to the granted port.
module rggen_bus_arbiter #(
   parameter int REQUESTERS     = 2,
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [REQUESTERS-1:0]               i_request_valid,
   input  logic [2*REQUESTERS-1:0]             i_request_access,
   input  logic [ADDRESS_WIDTH*REQUESTERS-1:0] i_request_address,
   input  logic [BUS_WIDTH*REQUESTERS-1:0]     i_request_write_data,
   input  logic [BUS_WIDTH/8*REQUESTERS-1:0]   i_request_strobe,
   output logic [REQUESTERS-1:0]               o_request_ready,
   output logic [2*REQUESTERS-1:0]             o_request_status,
   output logic [BUS_WIDTH*REQUESTERS-1:0]     o_request_read_data,
   output logic [REQUESTERS-1:0]               o_grant,
   output logic                                o_bus_valid,
   output logic [1:0]                          o_bus_access,
   output logic [ADDRESS_WIDTH-1:0]            o_bus_address,
   output logic [BUS_WIDTH-1:0]                o_bus_write_data,
   output logic [BUS_WIDTH/8-1:0]              o_bus_strobe,
   input  logic                                i_bus_ready,
   input  logic [1:0]                          i_bus_status,
   input  logic [BUS_WIDTH-1:0]                i_bus_read_data
);

   localparam int STRB_W = BUS_WIDTH / 8;
   localparam int IDX_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                    r_state;
   logic [REQUESTERS-1:0]     r_grant;
   logic [IDX_W-1:0]          r_ptr;
   logic                      r_bus_valid;
   logic [1:0]                r_bus_access;
   logic [ADDRESS_WIDTH-1:0]  r_bus_address;
   logic [BUS_WIDTH-1:0]      r_bus_write_data;
   logic [STRB_W-1:0]         r_bus_strobe;

   logic                      w_any_valid;
   logic [IDX_W-1:0]          w_winner;
   logic [1:0]                w_sel_access;
   logic [ADDRESS_WIDTH-1:0]  w_sel_address;
   logic [BUS_WIDTH-1:0]      w_sel_write_data;
   logic [STRB_W-1:0]         w_sel_strobe;
   logic [REQUESTERS-1:0]     w_request_ready;
   logic [2*REQUESTERS-1:0]   w_request_status;
   logic [BUS_WIDTH*REQUESTERS-1:0] w_request_read_data;

   // Winner: lowest valid index in fixed mode, otherwise the first valid port
   // found scanning upward (with wrap) from the one after the last winner.
   function automatic logic [IDX_W-1:0] pick_winner(input logic [REQUESTERS-1:0] valid,
                                                     input logic [IDX_W-1:0]      ptr);
      logic [IDX_W-1:0] winner;
      logic [IDX_W-1:0] idx;
      logic             found;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (FIXED_PRIORITY != 0) begin
            idx = IDX_W'(k);
         end else begin
            idx = IDX_W'((int'(ptr) + 1 + k) % REQUESTERS);
         end
         if (!found && valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end else begin
            found  = found;
         end
      end
      return winner;
   endfunction

   function automatic logic [REQUESTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [REQUESTERS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Select the winning port and mux out its request fields for capture.
   always_comb begin
      w_any_valid      = |i_request_valid;
      w_winner         = pick_winner(i_request_valid, r_ptr);
      w_sel_access     = i_request_access[2*int'(w_winner) +: 2];
      w_sel_address    = i_request_address[ADDRESS_WIDTH*int'(w_winner) +: ADDRESS_WIDTH];
      w_sel_write_data = i_request_write_data[BUS_WIDTH*int'(w_winner) +: BUS_WIDTH];
      w_sel_strobe     = i_request_strobe[STRB_W*int'(w_winner) +: STRB_W];
   end

   // Route the downstream completion to the granted port only, in the same cycle.
   always_comb begin
      w_request_ready     = '0;
      w_request_status    = '0;
      w_request_read_data = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if ((r_state == ST_BUSY) && r_grant[i] && i_bus_ready) begin
            w_request_ready[i]                          = 1'b1;
            w_request_status[2*i +: 2]                  = i_bus_status;
            w_request_read_data[BUS_WIDTH*i +: BUS_WIDTH] = i_bus_read_data;
         end else begin
            w_request_ready[i]                          = 1'b0;
            w_request_status[2*i +: 2]                  = 2'b00;
            w_request_read_data[BUS_WIDTH*i +: BUS_WIDTH] = '0;
         end
      end
   end

   // Arbitration FSM: capture the winner in IDLE, hold it stable until ready in BUSY.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state          <= ST_IDLE;
         r_grant          <= '0;
         r_ptr            <= IDX_W'(REQUESTERS - 1);
         r_bus_valid      <= 1'b0;
         r_bus_access     <= 2'b00;
         r_bus_address    <= '0;
         r_bus_write_data <= '0;
         r_bus_strobe     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_valid) begin
                  r_state          <= ST_BUSY;
                  r_grant          <= onehot(w_winner);
                  r_ptr            <= w_winner;
                  r_bus_valid      <= 1'b1;
                  r_bus_access     <= w_sel_access;
                  r_bus_address    <= w_sel_address;
                  r_bus_write_data <= w_sel_write_data;
                  r_bus_strobe     <= w_sel_strobe;
               end else begin
                  r_state     <= ST_IDLE;
                  r_grant     <= '0;
                  r_bus_valid <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (i_bus_ready) begin
                  r_state     <= ST_IDLE;
                  r_grant     <= '0;
                  r_bus_valid <= 1'b0;
               end else begin
                  r_state     <= ST_BUSY;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_grant     <= '0;
               r_bus_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant             = r_grant;
   assign o_bus_valid         = r_bus_valid;
   assign o_bus_access        = r_bus_access;
   assign o_bus_address       = r_bus_address;
   assign o_bus_write_data    = r_bus_write_data;
   assign o_bus_strobe        = r_bus_strobe;
   assign o_request_ready     = w_request_ready;
   assign o_request_status    = w_request_status;
   assign o_request_read_data = w_request_read_data;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Bench for rggen_bus_arbiter: a round-robin and a fixed-priority instance
// (three ports each) share the same stimulus and are compared against a
// transaction-level model of the arbitration rules.
module tb_rggen_bus_arbiter;

   localparam int R  = 3;
   localparam int AW = 8;
   localparam int BW = 32;

   logic            clk;
   logic            rst;
   logic [R-1:0]    req_valid;
   logic [2*R-1:0]  req_access;
   logic [AW*R-1:0] req_addr;
   logic [BW*R-1:0] req_wdata;
   logic [4*R-1:0]  req_strb;
   logic            bus_ready;
   logic [1:0]      bus_status;
   logic [BW-1:0]   bus_rdata;

   logic [R-1:0]    o_ready  [2];
   logic [2*R-1:0]  o_status [2];
   logic [BW*R-1:0] o_rdata  [2];
   logic [R-1:0]    o_grant  [2];
   logic            o_bvalid [2];
   logic [1:0]      o_bacc   [2];
   logic [AW-1:0]   o_baddr  [2];
   logic [BW-1:0]   o_bwdata [2];
   logic [3:0]      o_bstrb  [2];

   int errors = 0;
   int checks = 0;

   // model: whether a transfer is in flight, who owns it, what was captured
   bit            m_busy;
   int            m_owner [2];
   int            m_last;
   logic [1:0]    m_acc   [2];
   logic [AW-1:0] m_addr  [2];
   logic [BW-1:0] m_wd    [2];
   logic [3:0]    m_st    [2];

   rggen_bus_arbiter #(.REQUESTERS(R), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .FIXED_PRIORITY(0)) dut_rr (
      .i_clk(clk), .i_rst(rst),
      .i_request_valid(req_valid), .i_request_access(req_access), .i_request_address(req_addr),
      .i_request_write_data(req_wdata), .i_request_strobe(req_strb),
      .o_request_ready(o_ready[0]), .o_request_status(o_status[0]), .o_request_read_data(o_rdata[0]),
      .o_grant(o_grant[0]), .o_bus_valid(o_bvalid[0]), .o_bus_access(o_bacc[0]),
      .o_bus_address(o_baddr[0]), .o_bus_write_data(o_bwdata[0]), .o_bus_strobe(o_bstrb[0]),
      .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_rdata));

   rggen_bus_arbiter #(.REQUESTERS(R), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .FIXED_PRIORITY(1)) dut_fp (
      .i_clk(clk), .i_rst(rst),
      .i_request_valid(req_valid), .i_request_access(req_access), .i_request_address(req_addr),
      .i_request_write_data(req_wdata), .i_request_strobe(req_strb),
      .o_request_ready(o_ready[1]), .o_request_status(o_status[1]), .o_request_read_data(o_rdata[1]),
      .o_grant(o_grant[1]), .o_bus_valid(o_bvalid[1]), .o_bus_access(o_bacc[1]),
      .o_bus_address(o_baddr[1]), .o_bus_write_data(o_bwdata[1]), .o_bus_strobe(o_bstrb[1]),
      .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_rdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_winner(int d);
      if (d == 1) begin
         for (int p = 0; p < R; p++) if (req_valid[p]) return p;
      end else begin
         for (int k = 1; k <= R; k++) if (req_valid[(m_last + k) % R]) return (m_last + k) % R;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_last = R - 1;
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = 0; m_acc[d] = 2'b00; m_addr[d] = '0; m_wd[d] = '0; m_st[d] = 4'h0;
      end
   endtask

   task automatic model_edge();
      int w;
      if (rst) return;
      if (m_busy) begin
         if (bus_ready) m_busy = 1'b0;
      end else if (req_valid != 3'b000) begin
         for (int d = 0; d < 2; d++) begin
            w          = model_winner(d);
            m_owner[d] = w;
            m_acc[d]   = req_access[2*w +: 2];
            m_addr[d]  = req_addr[AW*w +: AW];
            m_wd[d]    = req_wdata[BW*w +: BW];
            m_st[d]    = req_strb[4*w +: 4];
         end
         m_last = m_owner[0];
         m_busy = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_port(int p, logic v, logic [1:0] acc, logic [AW-1:0] a, logic [BW-1:0] wd, logic [3:0] s);
      req_valid[p]          = v;
      req_access[2*p +: 2]  = acc;
      req_addr[AW*p +: AW]  = a;
      req_wdata[BW*p +: BW] = wd;
      req_strb[4*p +: 4]    = s;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_access = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
      bus_ready = 1'b0; bus_status = 2'b00; bus_rdata = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      #1;
      model_reset();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_grant[d] !== 3'b000 || o_bvalid[d] !== 1'b0 || o_baddr[d] !== 8'h00 ||
             o_bwdata[d] !== 32'h0 || o_bstrb[d] !== 4'h0 || o_bacc[d] !== 2'b00 || o_ready[d] !== 3'b000) begin
            errors++;
            $display("FAIL reset dut%0d got grant=%b valid=%b addr=%h ready=%b want all zero",
                     d, o_grant[d], o_bvalid[d], o_baddr[d], o_ready[d]);
         end
      end
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      set_port(0, 1'b1, 2'b01, 8'h10, 32'hDEADBEEF, 4'hF);
      #1;
      checks++;
      if (o_bvalid[0] !== 1'b0) begin errors++; $display("FAIL t1_idle got valid=%b want 0", o_bvalid[0]); end
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_bvalid[d] !== 1'b1 || o_grant[d] !== 3'b001 || o_baddr[d] !== 8'h10 ||
             o_bwdata[d] !== 32'hDEADBEEF || o_bstrb[d] !== 4'hF || o_bacc[d] !== 2'b01) begin
            errors++;
            $display("FAIL t1_capture dut%0d got v=%b g=%b a=%h d=%h s=%h acc=%b want 1 001 10 deadbeef f 01",
                     d, o_bvalid[d], o_grant[d], o_baddr[d], o_bwdata[d], o_bstrb[d], o_bacc[d]);
         end
      end
      bus_ready = 1'b1; bus_status = 2'b00;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_ready[d] !== 3'b001 || o_status[d] !== 6'b000000) begin
            errors++; $display("FAIL t1_ready dut%0d got ready=%b status=%b want 001 000000", d, o_ready[d], o_status[d]);
         end
      end
      tick();
      clear_inputs();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_bvalid[d] !== 1'b0 || o_grant[d] !== 3'b000) begin
            errors++; $display("FAIL t1_back_idle dut%0d got v=%b g=%b want 0 000", d, o_bvalid[d], o_grant[d]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] one;
      logic [2:0] exp_g;
      one = 3'b001;
      for (int p = 0; p < R; p++) set_port(p, 1'b1, 2'b01, 8'(8'h40 + 4*p), 32'hA000_0000 + p, 4'hF);
      for (int n = 0; n < 5; n++) begin
         bus_ready = 1'b0;
         #1;
         checks++;
         if (o_bvalid[0] !== 1'b0 || o_bvalid[1] !== 1'b0) begin
            errors++; $display("FAIL rr_gap n=%0d got v=%b%b want 00", n, o_bvalid[0], o_bvalid[1]);
         end
         tick();
         bus_ready = 1'b1;
         #1;
         exp_g = one << (n % 3);
         checks++;
         if (o_grant[0] !== exp_g || o_baddr[0] !== 8'(8'h40 + 4*(n % 3)) || o_ready[0] !== exp_g) begin
            errors++; $display("FAIL rr_order n=%0d got g=%b a=%h r=%b want g=%b", n, o_grant[0], o_baddr[0], o_ready[0], exp_g);
         end
         checks++;
         if (o_grant[1] !== 3'b001 || o_ready[1] !== 3'b001) begin
            errors++; $display("FAIL fp_port0 n=%0d got g=%b r=%b want 001", n, o_grant[1], o_ready[1]);
         end
         tick();
      end
      req_valid[0] = 1'b0; bus_ready = 1'b0;
      #1;
      tick();
      checks++;
      if (o_grant[1] !== 3'b010) begin errors++; $display("FAIL fp_drop got g=%b want 010", o_grant[1]); end
      bus_ready = 1'b1;
      #1;
      tick();
      clear_inputs();
      #1;
   endtask

   task automatic test_hold_stable();
      set_port(1, 1'b1, 2'b00, 8'h20, 32'h0, 4'h0);
      #1;
      tick();
      for (int c = 0; c < 5; c++) begin
         if (c == 1) req_addr[AW*1 +: AW] = 8'h24;
         if (c == 2) set_port(2, 1'b1, 2'b01, 8'h50, 32'h5555_AAAA, 4'h3);
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_baddr[d] !== 8'h20 || o_grant[d] !== 3'b010 || o_ready[d] !== 3'b000) begin
               errors++; $display("FAIL hold c=%0d dut%0d got a=%h g=%b r=%b want 20 010 000", c, d, o_baddr[d], o_grant[d], o_ready[d]);
            end
         end
         tick();
      end
      bus_ready = 1'b1;
      #1;
      checks++;
      if (o_ready[0] !== 3'b010) begin errors++; $display("FAIL hold_ready got %b want 010", o_ready[0]); end
      tick();
      bus_ready = 1'b0;
      #1;
      tick();
      checks++;
      if (o_grant[0] !== 3'b100 || o_baddr[0] !== 8'h50 || o_bstrb[0] !== 4'h3) begin
         errors++; $display("FAIL late_port2 got g=%b a=%h s=%h want 100 50 3", o_grant[0], o_baddr[0], o_bstrb[0]);
      end
      checks++;
      if (o_grant[1] !== 3'b010 || o_baddr[1] !== 8'h24) begin
         errors++; $display("FAIL fp_after_hold got g=%b a=%h want 010 24", o_grant[1], o_baddr[1]);
      end
      bus_ready = 1'b1;
      #1;
      tick();
      clear_inputs();
      #1;
   endtask

   task automatic test_read_response();
      set_port(2, 1'b1, 2'b00, 8'h30, 32'h0, 4'h0);
      #1;
      tick();
      bus_ready = 1'b1; bus_status = 2'b10; bus_rdata = 32'h12345678;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_ready[d] !== 3'b100 || o_status[d] !== 6'b100000 ||
             o_rdata[d] !== {32'h12345678, 32'h0, 32'h0} || o_bacc[d] !== 2'b00) begin
            errors++; $display("FAIL read_route dut%0d got r=%b st=%b rd=%h want 100 100000 12345678_0_0",
                               d, o_ready[d], o_status[d], o_rdata[d]);
         end
      end
      tick();
      clear_inputs();
      #1;
   endtask

   task automatic test_reset_busy();
      set_port(0, 1'b1, 2'b01, 8'h60, 32'h0BAD_F00D, 4'hC);
      set_port(1, 1'b1, 2'b01, 8'h64, 32'h1111_2222, 4'h1);
      #1;
      tick();
      bus_ready = 1'b1; bus_status = 2'b01; bus_rdata = 32'hFFFF_0000;
      #2;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_grant[d] !== 3'b000 || o_bvalid[d] !== 1'b0 || o_ready[d] !== 3'b000 ||
             o_status[d] !== 6'b000000 || o_baddr[d] !== 8'h00 || o_rdata[d] !== 96'h0) begin
            errors++; $display("FAIL rst_busy dut%0d got g=%b v=%b r=%b a=%h want zeros", d, o_grant[d], o_bvalid[d], o_ready[d], o_baddr[d]);
         end
      end
      model_reset();
      tick();
      rst = 1'b0; bus_ready = 1'b0;
      #1;
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_grant[d] !== 3'b001 || o_baddr[d] !== 8'h60) begin
            errors++; $display("FAIL rst_first dut%0d got g=%b a=%h want 001 60", d, o_grant[d], o_baddr[d]);
         end
      end
      bus_ready = 1'b1;
      #1;
      tick();
      clear_inputs();
      #1;
   endtask

   task automatic test_random();
      logic [2:0]    one;
      logic [2:0]    exp_g;
      logic [2:0]    exp_r;
      logic [5:0]    exp_st;
      logic [95:0]   exp_rd;
      one = 3'b001;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < R; p++)
            set_port(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                     32'($urandom), 4'($urandom_range(0, 15)));
         bus_ready  = 1'($urandom_range(0, 1));
         bus_status = 2'($urandom_range(0, 3));
         bus_rdata  = 32'($urandom);
         #1;
         for (int d = 0; d < 2; d++) begin
            exp_g  = m_busy ? (one << m_owner[d]) : 3'b000;
            exp_r  = exp_g & {3{bus_ready}};
            exp_st = '0;
            exp_rd = '0;
            for (int p = 0; p < R; p++) begin
               if (exp_r[p]) begin
                  exp_st[2*p +: 2]  = bus_status;
                  exp_rd[BW*p +: BW] = bus_rdata;
               end
            end
            checks++;
            if (o_grant[d] !== exp_g || o_bvalid[d] !== m_busy) begin
               errors++; $display("FAIL rnd_grant cyc=%0d dut%0d got g=%b v=%b want g=%b v=%b", cyc, d, o_grant[d], o_bvalid[d], exp_g, m_busy);
            end
            checks++;
            if (o_bacc[d] !== m_acc[d] || o_baddr[d] !== m_addr[d] || o_bwdata[d] !== m_wd[d] || o_bstrb[d] !== m_st[d]) begin
               errors++; $display("FAIL rnd_fields cyc=%0d dut%0d got %b/%h/%h/%h want %b/%h/%h/%h", cyc, d,
                                  o_bacc[d], o_baddr[d], o_bwdata[d], o_bstrb[d], m_acc[d], m_addr[d], m_wd[d], m_st[d]);
            end
            checks++;
            if (o_ready[d] !== exp_r || o_status[d] !== exp_st || o_rdata[d] !== exp_rd) begin
               errors++; $display("FAIL rnd_resp cyc=%0d dut%0d got r=%b st=%b rd=%h want r=%b st=%b rd=%h", cyc, d,
                                  o_ready[d], o_status[d], o_rdata[d], exp_r, exp_st, exp_rd);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      #1;
      test_reset();
      test_round_robin();
      test_single_write();
      test_hold_stable();
      test_read_response();
      test_reset_busy();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
